// File: rtl/dual_wb_regfile.sv
// Writeback stage and architectural register file for the two-lane execute
// path: commits two tagged lane results, serves four bypassed read ports and
// keeps a per-register busy scoreboard for RAW/WAW issue stalls.

// One read port: write-through bypass from the committing lanes plus operand
// readiness against the scoreboard.
module dual_wb_rd_port #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            busy_bit,
    input  logic            a_eff,
    input  logic            b_eff,
    input  logic            wa_we,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] rdata,
    output logic            rrdy
);
    logic zero;
    logic clr;

    assign zero = (raddr == '0);
    // A raw writeback to this register clears pending status, even if the
    // data lost a same-address collision (the winner carries the value).
    assign clr  = (wa_we && wa_addr == raddr) || (wb_we && wb_addr == raddr);
    assign rrdy = zero || !busy_bit || clr;

    // Bypass select; a_eff/b_eff are already collision-resolved, so at most
    // one of them can match a given nonzero address.
    always_comb begin
        rdata = rf_data;
        if (zero)
            rdata = '0;
        else if (a_eff && wa_addr == raddr)
            rdata = wa_data;
        else if (b_eff && wb_addr == raddr)
            rdata = wb_data;
    end
endmodule

module dual_wb_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wa_we,
    input  logic                    wa_num,
    input  logic [$clog2(NREG)-1:0] wa_addr,
    input  logic [XLEN-1:0]         wa_data,
    input  logic                    wb_we,
    input  logic                    wb_num,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    iss_we0,
    input  logic                    iss_we1,
    input  logic [$clog2(NREG)-1:0] iss_rd0,
    input  logic [$clog2(NREG)-1:0] iss_rd1,
    input  logic [$clog2(NREG)-1:0] raddr0,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    input  logic [$clog2(NREG)-1:0] raddr3,
    output logic [XLEN-1:0]         rdata0,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    output logic [XLEN-1:0]         rdata3,
    output logic                    rrdy0,
    output logic                    rrdy1,
    output logic                    rrdy2,
    output logic                    rrdy3,
    output logic                    waw0,
    output logic                    waw1,
    output logic [NREG-1:0]         busy_vec
);
    localparam int AW = $clog2(NREG);
    localparam int NRP = 4;

    logic [XLEN-1:0] gpr [NREG];
    logic [NREG-1:0] busy, busy_nxt;

    logic a_hit, b_hit, collide, a_wins, a_eff, b_eff;

    logic [NRP-1:0][AW-1:0]   raddr_v;
    logic [NRP-1:0][XLEN-1:0] rdata_v;
    logic [NRP-1:0]           rrdy_v;

    // Commit arbitration: on a same-address collision the younger (num=1)
    // lane wins; equal nums are illegal and fall to lane B.
    assign a_hit   = wa_we && (wa_addr != '0);
    assign b_hit   = wb_we && (wb_addr != '0);
    assign collide = a_hit && b_hit && (wa_addr == wb_addr);
    assign a_wins  = wa_num && !wb_num;
    assign a_eff   = a_hit && !(collide && !a_wins);
    assign b_eff   = b_hit && !(collide && a_wins);

    // GPR array; x0 is never written so it stays zero from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) gpr[r] <= '0;
        end else begin
            if (a_eff) gpr[wa_addr] <= wa_data;
            if (b_eff) gpr[wb_addr] <= wb_data;
        end
    end

    // Scoreboard next state: a new producer (set) beats a retiring one (clr).
    always_comb begin
        busy_nxt = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_nxt[r] = (iss_we0 && iss_rd0 == AW'(r)) ||
                          (iss_we1 && iss_rd1 == AW'(r)) ||
                          (busy[r] && !((wa_we && wa_addr == AW'(r)) ||
                                        (wb_we && wb_addr == AW'(r))));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_vec = busy;

    assign waw0 = iss_we0 && (iss_rd0 != '0) && busy[iss_rd0] &&
                  !((wa_we && wa_addr == iss_rd0) || (wb_we && wb_addr == iss_rd0));
    assign waw1 = iss_we1 && (iss_rd1 != '0) && busy[iss_rd1] &&
                  !((wa_we && wa_addr == iss_rd1) || (wb_we && wb_addr == iss_rd1));

    assign raddr_v = {raddr3, raddr2, raddr1, raddr0};

    generate
        for (genvar i = 0; i < NRP; i++) begin : g_rp
            dual_wb_rd_port #(.XLEN(XLEN), .AW(AW)) u_rp (
                .raddr    (raddr_v[i]),
                .rf_data  (gpr[raddr_v[i]]),
                .busy_bit (busy[raddr_v[i]]),
                .a_eff    (a_eff),
                .b_eff    (b_eff),
                .wa_we    (wa_we),
                .wa_addr  (wa_addr),
                .wa_data  (wa_data),
                .wb_we    (wb_we),
                .wb_addr  (wb_addr),
                .wb_data  (wb_data),
                .rdata    (rdata_v[i]),
                .rrdy     (rrdy_v[i])
            );
        end
    endgenerate

    assign {rdata3, rdata2, rdata1, rdata0} = rdata_v;
    assign {rrdy3, rrdy2, rrdy1, rrdy0}     = rrdy_v;
endmodule

// File: doc/dual_wb_regfile.md
Name: dual_wb_regfile

Overview:
- Writeback stage and architectural register file for the two-lane execute path.
- Takes the two registered execute-lane results (each tagged with the 1-bit order number), commits them to 32x32 GPRs, and serves four read ports (two per issue lane) with write-through bypass.
- Keeps a per-register busy scoreboard. Issue uses it to stall RAW and WAW hazards against in-flight execute results.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired to zero).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wa_we  in  1  lane A writeback enable
- wa_num  in  1  lane A order number (1 = younger)
- wa_addr  in  5  lane A destination register
- wa_data  in  XLEN  lane A write data
- wb_we  in  1  lane B writeback enable
- wb_num  in  1  lane B order number
- wb_addr  in  5  lane B destination register
- wb_data  in  XLEN  lane B write data
- iss_we0, iss_we1  in  1 each  issue lane 0/1 instruction will write rd (issue fires this cycle)
- iss_rd0, iss_rd1  in  5 each  issue lane 0/1 destination register
- raddr0..raddr3  in  5 each  read addresses (0,1 = issue lane 0 rs1/rs2; 2,3 = lane 1)
- rdata0..rdata3  out  XLEN each  read data, combinational
- rrdy0..rrdy3  out  1 each  operand valid (not pending, or bypassed this cycle)
- waw0, waw1  out  1 each  iss_rd of lane 0/1 is busy and not cleared this cycle
- busy_vec  out  NREG  scoreboard state (debug/verification)

Behaviour:
- Reset (async, immediate): all GPRs = 0; busy_vec = 0.
  - Outputs then follow combinationally: rdata* = 0, rrdy* = 1, waw* = 0.
- x0: writes to addr 0 are discarded. Reads of addr 0 return 0 with rrdy = 1. iss_we with rd = 0 never sets busy.
- Commit: on the rising clk edge, each lane with we = 1 and addr != 0 writes its data.
- Same-cycle same-address commit (both lanes, same addr != 0):
  - The lane with num = 1 wins.
  - If wa_num == wb_num (illegal), lane B wins.
  - A single write occurs, with the winning data.
- Read bypass (combinational), for each read port:
  - If a committing lane targets raddr (!= 0), rdata = that lane's data, with the same winner rule as commit.
  - Otherwise rdata = GPR contents.
  - Zero-cycle latency.
- Scoreboard next-state per register r != 0:
  - clr = (wa_we & wa_addr == r) | (wb_we & wb_addr == r)
  - set = (iss_we0 & iss_rd0 == r) | (iss_we1 & iss_rd1 == r)
  - busy'[r] = set | (busy[r] & ~clr)
  - Set and clear on the same edge: set wins, because the new producer is in flight.
- rrdyN = (raddrN == 0) | ~busy[raddrN] | clr(raddrN).
  - Current-cycle issue does not affect rrdy.
  - Same-bundle lane0 -> lane1 dependency is the issue stage's responsibility.
- wawN = iss_weN & (iss_rdN != 0) & busy[iss_rdN] & ~clr(iss_rdN).
  - Issue must not fire while waw* or ~rrdy* is asserted.
  - If it fires anyway, busy stays set; no error state is kept.
- Busy is one bit per register. Correctness relies on the WAW stall, so at most one writer per register is in flight.
- A writeback to a non-busy register is legal (no scoreboard effect other than a no-op clear).
- rst asserted mid-operation: GPRs and busy clear immediately; in-flight writebacks on that edge are dropped.
- No stop/stall input. Upstream holds wa_we/wb_we low while frozen; the execute stage's register already holds its value.

Test Plan:
- Reset then read: assert rst, release; raddr0..3 = 1,2,3,31 -> rdata all 0, rrdy all 1, busy_vec = 0.
- Single commit + bypass: wa_we=1, wa_addr=5, wa_data=0xDEADBEEF, raddr0=5 -> same cycle rdata0 = 0xDEADBEEF; next cycle, with wa_we=0, rdata0 still 0xDEADBEEF.
- Ordered collision: wa(addr 7, num 0, 0x11), wb(addr 7, num 1, 0x22) -> rdata = 0x22 same cycle and after the edge. Swap nums -> 0x11.
- x0 protection: wb_we=1, wb_addr=0, data 0xFFFFFFFF; iss_we0=1, iss_rd0=0 -> raddr 0 reads 0, rrdy=1, busy_vec[0]=0.
- Scoreboard lifecycle: iss_we0 rd=9 -> next cycle busy_vec[9]=1, rrdy for raddr 9 = 0, waw1 with iss_rd1=9 = 1. Then wa commit addr 9 data 0x55 -> same cycle rrdy = 1, rdata = 0x55; after the edge busy[9] = 0.
- Set/clear collision and async reset: commit wb addr 12 while iss_we1 rd=12 -> busy[12] = 1 after the edge. Pulse rst between edges -> busy_vec = 0 and GPR 12 = 0 immediately, without a clock edge.
